// File: rtl/voice_volume_classifier.sv
// Stereo volume classifier: handshakes codec samples, reduces each frame to a
// saturated absolute peak and drives walk/jump through a hysteresis FSM.
module voice_volume_classifier #(
    parameter int           W         = 24,
    parameter int           FRAME_LEN = 800,
    parameter logic [W-1:0] WALK_ON   = 24'h002fff,
    parameter logic [W-1:0] WALK_OFF  = 24'h001fff,
    parameter logic [W-1:0] JUMP_ON   = 24'h0100ff,
    parameter logic [W-1:0] JUMP_OFF  = 24'h00c000,
    parameter int           JUMP_HOLD = 6
) (
    input  logic         clk_50,
    input  logic         resetn,
    input  logic [W-1:0] left,
    input  logic [W-1:0] right,
    input  logic         read_ready,
    input  logic [1:0]   mode,
    output logic         read,
    output logic         walk,
    output logic         jump,
    output logic [W-1:0] peak,
    output logic         frame_done
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [3:0]  HOLD_LD  = 4'(JUMP_HOLD);

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_JUMP} state_t;

    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] x);
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        else if (x < 0)
            return -x;
        else
            return x;
    endfunction

    function automatic logic [W-1:0] umax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic signed [W-1:0] r_left_p0, r_right_p0;
    logic [1:0]          r_mode_p0;
    logic                r_vld_p0;
    logic [W-1:0]        r_run_p1, r_peak_p1;
    logic [15:0]         r_cnt_p1;
    logic                r_vld_p1;
    state_t              r_state_p2, w_state_nxt;
    logic [3:0]          r_hold_p2, w_hold_nxt;

    logic signed [W:0]   w_sum;
    logic signed [W-1:0] w_avg;
    logic [W-1:0]        w_abs_l, w_abs_r, w_mag, w_run_max;
    logic                w_accept;

    assign w_accept = read_ready && !r_vld_p0;

    // Stage 0: capture the sample pair and mode on accept
    always_ff @(posedge clk_50) begin
        if (w_accept) begin
            r_left_p0  <= left;
            r_right_p0 <= right;
            r_mode_p0  <= mode;
        end
    end

    // Stage 1: magnitude per captured mode, running max and frame counter
    // Bits [W:1] of the widened sum are the arithmetic shift right by one.
    assign w_sum   = {r_left_p0[W-1], r_left_p0} + {r_right_p0[W-1], r_right_p0};
    assign w_avg   = w_sum[W:1];
    assign w_abs_l = abs_sat(r_left_p0);
    assign w_abs_r = abs_sat(r_right_p0);

    always_comb begin
        w_mag = w_abs_l;
        case (r_mode_p0)
            2'b00:   w_mag = w_abs_l;
            2'b01:   w_mag = w_abs_r;
            2'b10:   w_mag = umax(w_abs_l, w_abs_r);
            default: w_mag = abs_sat(w_avg);
        endcase
    end

    assign w_run_max = umax(r_run_p1, w_mag);

    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_run_p1  <= '0;
            r_cnt_p1  <= '0;
            r_peak_p1 <= '0;
        end else begin
            r_vld_p0 <= w_accept;
            r_vld_p1 <= 1'b0;
            if (r_vld_p0) begin
                if (r_cnt_p1 == LAST_IDX) begin
                    r_peak_p1 <= w_run_max;
                    r_run_p1  <= '0;
                    r_cnt_p1  <= '0;
                    r_vld_p1  <= 1'b1;
                end else begin
                    r_run_p1 <= w_run_max;
                    r_cnt_p1 <= r_cnt_p1 + 16'd1;
                end
            end
        end
    end

    // Stage 2: hysteresis FSM, evaluated only when a new peak lands
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            r_state_p2 <= ST_IDLE;
            r_hold_p2  <= '0;
        end else begin
            r_state_p2 <= w_state_nxt;
            r_hold_p2  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state_p2;
        w_hold_nxt  = r_hold_p2;
        if (r_vld_p1) begin
            case (r_state_p2)
                ST_IDLE: begin
                    if (r_peak_p1 >= JUMP_ON) begin
                        w_state_nxt = ST_JUMP;
                        w_hold_nxt  = HOLD_LD;
                    end else if (r_peak_p1 >= WALK_ON) begin
                        w_state_nxt = ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (r_peak_p1 >= JUMP_ON) begin
                        w_state_nxt = ST_JUMP;
                        w_hold_nxt  = HOLD_LD;
                    end else if (r_peak_p1 < WALK_OFF) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_JUMP: begin
                    if (r_peak_p1 >= JUMP_ON) begin
                        w_hold_nxt = HOLD_LD;
                    end else if (r_hold_p2 != 4'd0) begin
                        w_hold_nxt = r_hold_p2 - 4'd1;
                    end else if (r_peak_p1 < JUMP_OFF) begin
                        w_state_nxt = (r_peak_p1 >= WALK_OFF) ? ST_WALK : ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign read       = r_vld_p0;
    assign frame_done = r_vld_p1;
    assign peak       = r_peak_p1;
    assign walk       = (r_state_p2 == ST_WALK) || (r_state_p2 == ST_JUMP);
    assign jump       = (r_state_p2 == ST_JUMP);

endmodule

// File: doc/voice_volume_classifier.md
# voice_volume_classifier

Parametrised successor to the single-sample volume detector in the audio front end. Accepts stereo codec samples through the read_ready/read handshake and selects or combines channels per a runtime mode. Reduces each frame of FRAME_LEN samples to a saturated absolute peak, then drives the game's walk/jump controls through a hysteresis state machine with a jump hold time. Sits between the audio codec FIFO interface and the character-motion logic, all in the clk_50 domain.

## Interface
- W, 24: sample width, two's complement
- FRAME_LEN, 800: samples per analysis frame (48 kHz / 60 Hz); legal range 2..65535
- WALK_ON, 24'h002fff: frame peak at or above this enters walk
- WALK_OFF, 24'h001fff: frame peak below this leaves walk; must satisfy WALK_OFF <= WALK_ON
- JUMP_ON, 24'h0100ff: frame peak at or above this enters or re-triggers jump; must satisfy JUMP_ON > WALK_ON
- JUMP_OFF, 24'h00c000: jump may end only once the frame peak is below this; must satisfy JUMP_OFF <= JUMP_ON
- JUMP_HOLD, 6: minimum number of additional frames jump stays asserted after a trigger; legal range 0..15

- clk_50  in  1  system clock; all logic is synchronous to its rising edge
- resetn  in  1  synchronous active-low reset
- left  in  W  left-channel sample
- right  in  W  right-channel sample
- read_ready  in  1  codec has a sample pair available
- mode  in  2  channel select: 00 left, 01 right, 10 max(|L|,|R|), 11 |(L+R)>>>1|
- read  out  1  one-cycle acknowledge pulse that pops the codec FIFO
- walk  out  1  walk command (registered)
- jump  out  1  jump command (registered)
- peak  out  W  peak of the last completed frame (registered)
- frame_done  out  1  one-cycle pulse when peak updates

## Operation
- **Accept rule.** A sample pair is accepted on an edge where read_ready=1 and read=0.
  - On that edge, left, right and mode are captured and read is set to 1 for exactly one cycle.
  - read_ready is ignored while read=1, so back-to-back accepts are at most every 2 cycles.
- **Magnitude.** Absolute value saturates: -2^(W-1) maps to 2^(W-1)-1.
  - Mode 11 forms L+R at W+1 bits, arithmetic-shifts right by 1, then takes the absolute value.
  - Mode 10 takes the larger of the two saturated absolutes.
  - mode may change between samples; each sample uses the mode captured with it.
- **Framing.** A running maximum and a sample counter (0..FRAME_LEN-1) update once per accepted sample.
  - On the sample where the counter equals FRAME_LEN-1:
    - peak <= max(running, this magnitude);
    - running <= 0;
    - counter <= 0;
    - frame_done pulses.
  - Otherwise running <= max(running, magnitude) and the counter increments.
- **State machine.** States are IDLE, WALK and JUMP, plus a 4-bit hold counter. The state is evaluated only on frame_done, using P = the new peak.
  - IDLE:
    - P >= JUMP_ON -> JUMP, hold <= JUMP_HOLD;
    - else P >= WALK_ON -> WALK;
    - else stay in IDLE.
  - WALK:
    - P >= JUMP_ON -> JUMP, hold <= JUMP_HOLD;
    - else P < WALK_OFF -> IDLE;
    - else stay in WALK.
  - JUMP:
    - P >= JUMP_ON -> hold <= JUMP_HOLD (re-trigger);
    - else hold > 0 -> hold decrements;
    - else P < JUMP_OFF -> WALK if P >= WALK_OFF, else IDLE;
    - else stay in JUMP.
- **Outputs.**
  - walk = 1 in WALK and in JUMP.
  - jump = 1 in JUMP only.
  - Outputs never change except on the edge following frame_done.
- **Reset.** resetn=0 on any edge clears everything, including mid-frame and mid-handshake:
  - read, walk, jump, frame_done and peak go to 0;
  - the counter, running maximum and hold counter go to 0;
  - the state goes to IDLE.
  - The first sample accepted after reset starts a fresh frame.

## Timing
- Edge E: accept the sample; read=1 during cycle E..E+1.
- Edge E+1: magnitude and running maximum update; on the final sample of a frame, peak updates and frame_done=1 during cycle E+1..E+2.
- Edge E+2: state, walk and jump update.
- Latency from the accept of the last sample in a frame: 2 edges to peak/frame_done, 3 edges to walk/jump.
- The pipeline is fully registered and holds at most one sample in flight per stage, so a new accept can never overrun it.

## Test plan
- **Reset and handshake.**
  - Stimulus: hold resetn=0 for 3 cycles, then hold read_ready=1 continuously.
  - Required response: all outputs are 0 during reset; read then pulses every other cycle and is never high for two consecutive cycles.
- **Saturation.**
  - Stimulus: FRAME_LEN=4, mode 00, left = 24'h800000 followed by three zero samples.
  - Required response: peak = 24'h7fffff and frame_done pulses once, 2 edges after the 4th accept.
- **Mode coverage.**
  - Stimulus: L = 24'h003000, R = 24'hFF0000 (-65536), one frame per mode.
  - Required response: mode 00 -> peak 24'h003000; mode 01 -> 24'h010000; mode 10 -> 24'h010000; mode 11 -> 24'h006800.
- **Walk hysteresis.**
  - Stimulus: frame peaks of 24'h003000, then 24'h002500, then 24'h001000.
  - Required response: walk = 1 after frame 1, stays 1 after frame 2, and returns to 0 after frame 3; jump stays 0 throughout.
- **Jump hold and re-trigger.**
  - Stimulus: JUMP_HOLD=2; frame peaks of 24'h020000, then 0, 0, 0.
  - Required response: jump = 1 for frames 1-3 and drops after frame 4 with walk = 0.
  - Repeat with a 24'h020000 frame inserted at frame 3: the hold reloads, so jump = 1 through frame 5.
- **Reset mid-frame.**
  - Stimulus: FRAME_LEN=4; accept 2 loud samples, pulse resetn=0 for 1 cycle, then accept 4 quiet samples.
  - Required response: outputs and peak clear on the reset; the next frame_done comes after exactly 4 post-reset samples with peak equal to the quiet magnitude.
